dn_counter: RTL and testbench

Synchronous loadable down counter with terminal-count pulse and optional auto-reload; it counts in the opposite direction of the team's 4-bit up ripple counter. It serves as a programmable interval/timeout source next to the up counters in the counter library. All state changes on the falling edge of `clk`, the same active edge used by the counter library. Unlike the ripple counter, it is fully synchronous (single clock domain, no derived clocks).

---
 rtl/dn_counter.sv | 82 ++++++++
 tb/tb_dn_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dn_counter.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// All state updates on the falling edge of clk; asynchronous active-low reset.
module dn_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] rld, rld_nx;
    logic [WIDTH-1:0] q_nx;
    logic             tc_nx;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            rld   <= rld_nx;
            tc    <= tc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        q_nx     = q;
        rld_nx   = rld;
        tc_nx    = 1'b0;
        if (load) begin
            q_nx     = din;
            rld_nx   = din;
            state_nx = (din != '0) ? RUN : DONE;
        end else begin
            unique case (state)
                RUN: begin
                    if (en) begin
                        // q==0 never occurs in RUN, so q==1 is the only terminal value
                        if (q == WIDTH'(1)) begin
                            tc_nx = 1'b1;
                            if (auto_reload) begin
                                q_nx = rld;
                            end else begin
                                q_nx     = '0;
                                state_nx = DONE;
                            end
                        end else begin
                            q_nx = q - WIDTH'(1);
                        end
                    end
                end
                IDLE, DONE: q_nx = '0;
                default: begin
                    state_nx = IDLE;
                    q_nx     = '0;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_dn_counter.sv
// Scoreboard bench for dn_counter: stimulus pushes model expectations per falling
// edge, a monitor pops and compares shortly after each falling edge.
module tb_dn_counter;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    dn_counter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .din         (din),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 counting, 2 finished
    int m_mode = 0;
    int m_q    = 0;
    int m_rld  = 0;
    int m_tc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one falling edge worth of inputs and predict its result.
    task automatic step(input logic r, input logic ld, input int d, input logic e, input logic ar);
        exp_t x;
        @(posedge clk);
        reset       = r;
        load        = ld;
        din         = W'(d);
        en          = e;
        auto_reload = ar;
        if (!r) begin
            m_mode = 0; m_q = 0; m_rld = 0; m_tc = 0;
        end else if (ld) begin
            m_q = d; m_rld = d; m_tc = 0;
            m_mode = (d != 0) ? 1 : 2;
        end else if (m_mode == 1 && e) begin
            if (m_q == 1) begin
                m_tc = 1;
                if (ar) m_q = m_rld;
                else begin
                    m_q = 0; m_mode = 2;
                end
            end else begin
                m_q  = m_q - 1;
                m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
        x.q    = W'(m_q);
        x.tc   = (m_tc != 0);
        x.busy = (m_mode == 1);
        x.done = (m_mode == 2);
        exp_q.push_back(x);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("q",    32'(q),    32'(x.q));
                check("tc",   32'(tc),   32'(x.tc));
                check("busy", 32'(busy), 32'(x.busy));
                check("done", 32'(done), 32'(x.done));
            end
        end
    end

    initial begin
        reset = 1'b1; load = 1'b0; din = '0; en = 1'b0; auto_reload = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_q",    32'(q),    0);
        check("rst_tc",   32'(tc),   0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);

        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);

        // one-shot from 3, then hold in DONE
        step(1, 1, 3, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0);

        // auto-reload period 2
        step(1, 1, 2, 1, 1);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1);

        // enable gating
        step(1, 1, 4, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, (i % 2) == 0, 0);

        // load priority, zero load, load on terminal edge
        step(1, 1, 6, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 1, 1, 1, 0);
        step(1, 1, 9, 1, 0);
        step(1, 0, 0, 1, 0);

        // en low on would-be terminal edge, reload period 1
        step(1, 1, 2, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1);

        // full scale reload
        step(1, 1, 15, 1, 1);
        for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 1);

        // asynchronous reset mid-count with q=5
        step(1, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_q",    32'(q),    0);
        check("async_tc",   32'(tc),   0);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) != 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
